mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_pkg.sv | 25 ++
 rtl/mem_stage_ctrl_wait_counter.sv | 38 +++
 rtl/mem_stage_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline constants: opcode field, memory opcodes, default address width.
// Also holds the MEM-stage FSM state type and opcode decode helpers.
package mem_stage_ctrl_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int OPC_MSB    = 31;
  localparam int OPC_LSB    = 27;

  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_SW = 5'b00111;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic [4:0] opcode_of(input logic [31:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic is_mem_op(input logic [31:0] ir);
    return (opcode_of(ir) == OP_LW) || (opcode_of(ir) == OP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_wait_counter.sv
// Counts ACCESS cycles that pass without an ack; tc_o flags the last allowed cycle.
// Cleared on ACCESS entry; the parent leaves ACCESS when tc_o is seen, so no saturation is needed.
module mem_wait_counter #(
  parameter int MAX_WAIT = 255
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A count of MAX_WAIT-1 means this is the MAX_WAIT-th ack-less ACCESS cycle.
  assign tc_o = (count_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: non-memory ops pass through in one cycle; LW/SW stall the pipe
// in ACCESS until dmem_ack or a wait timeout, which sets the sticky mem_err flag.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 255
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              xm_valid,
  input  logic [31:0]       xm_O,
  input  logic [31:0]       xm_B,
  input  logic [31:0]       xm_ir,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mw_valid,
  output logic [31:0]       mw_O,
  output logic [31:0]       mw_D,
  output logic [31:0]       mw_ir,
  output logic              mem_err
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       o_q, o_d;
  logic              mw_valid_q, mw_valid_d;
  logic [31:0]       mw_o_q, mw_o_d;
  logic [31:0]       mw_d_q, mw_d_d;
  logic [31:0]       mw_ir_q, mw_ir_d;
  logic              err_q, err_d;
  logic              cnt_clr, cnt_en, cnt_tc;

  mem_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    ir_d       = ir_q;
    o_d        = o_q;
    mw_valid_d = mw_valid_q;
    mw_o_d     = mw_o_q;
    mw_d_d     = mw_d_q;
    mw_ir_d    = mw_ir_q;
    err_d      = err_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!xm_valid) begin
          mw_valid_d = 1'b0;
          mw_o_d     = '0;
          mw_d_d     = '0;
          mw_ir_d    = '0;
        end else if (is_mem_op(xm_ir)) begin
          state_d    = ST_ACCESS;
          addr_d     = xm_O[ADDR_W-1:0];
          we_d       = (opcode_of(xm_ir) == OP_SW);
          if (opcode_of(xm_ir) == OP_SW) begin
            wdata_d = xm_B;
          end
          ir_d       = xm_ir;
          o_d        = xm_O;
          mw_valid_d = 1'b0;
          cnt_clr    = 1'b1;
        end else begin
          mw_valid_d = 1'b1;
          mw_o_d     = xm_O;
          mw_d_d     = '0;
          mw_ir_d    = xm_ir;
        end
      end

      ST_ACCESS: begin
        mw_valid_d = 1'b0;
        // An ack on the terminal wait cycle wins over the timeout.
        if (dmem_ack || cnt_tc) begin
          state_d    = ST_IDLE;
          mw_valid_d = 1'b1;
          mw_o_d     = o_q;
          mw_ir_d    = ir_q;
          mw_d_d     = (dmem_ack && !we_q) ? dmem_rdata : '0;
          if (!dmem_ack) begin
            err_d = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      ir_q       <= '0;
      o_q        <= '0;
      mw_valid_q <= 1'b0;
      mw_o_q     <= '0;
      mw_d_q     <= '0;
      mw_ir_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      ir_q       <= ir_d;
      o_q        <= o_d;
      mw_valid_q <= mw_valid_d;
      mw_o_q     <= mw_o_d;
      mw_d_q     <= mw_d_d;
      mw_ir_q    <= mw_ir_d;
      err_q      <= err_d;
    end
  end

  assign stall      = (state_q == ST_ACCESS);
  assign dmem_req   = (state_q == ST_ACCESS);
  assign dmem_we    = (state_q == ST_ACCESS) && we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign mw_valid   = mw_valid_q;
  assign mw_O       = mw_o_q;
  assign mw_D       = mw_d_q;
  assign mw_ir      = mw_ir_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a transaction-level model is compared every cycle,
// and hand-computed literals pin the key scenarios.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  localparam int AW = 12;
  localparam int MW = 4;

  localparam logic [31:0] IR_LW  = {OP_LW, 27'd5};
  localparam logic [31:0] IR_SW  = {OP_SW, 27'd9};
  localparam logic [31:0] IR_ALU = 32'h0000_00AB;

  logic          clock = 1'b0;
  logic          ctrl_reset;
  logic          xm_valid;
  logic [31:0]   xm_O, xm_B, xm_ir;
  logic          stall, dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic          dmem_ack;
  logic [31:0]   dmem_rdata;
  logic          mw_valid;
  logic [31:0]   mw_O, mw_D, mw_ir;
  logic          mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_stage_ctrl #(
    .ADDR_W   (AW),
    .MAX_WAIT (MW)
  ) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .xm_valid   (xm_valid),
    .xm_O       (xm_O),
    .xm_B       (xm_B),
    .xm_ir      (xm_ir),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .mw_valid   (mw_valid),
    .mw_O       (mw_O),
    .mw_D       (mw_D),
    .mw_ir      (mw_ir),
    .mem_err    (mem_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one outstanding memory transaction plus the last MW-stage result.
  logic          m_busy = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_wdata = '0, m_O = '0, m_ir = '0;
  int            m_waited = 0;
  logic          e_valid = 1'b0, e_err = 1'b0;
  logic [31:0]   e_O = '0, e_D = '0, e_ir = '0;

  always @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      m_busy <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0; m_O <= '0; m_ir <= '0;
      m_waited <= 0; e_valid <= 1'b0; e_O <= '0; e_D <= '0; e_ir <= '0; e_err <= 1'b0;
    end else if (!m_busy) begin
      if (!xm_valid) begin
        e_valid <= 1'b0; e_O <= '0; e_D <= '0; e_ir <= '0;
      end else if (xm_ir[31:27] == OP_LW || xm_ir[31:27] == OP_SW) begin
        m_busy   <= 1'b1;
        m_we     <= (xm_ir[31:27] == OP_SW);
        m_addr   <= xm_O[AW-1:0];
        if (xm_ir[31:27] == OP_SW) m_wdata <= xm_B;
        m_O      <= xm_O;
        m_ir     <= xm_ir;
        m_waited <= 0;
        e_valid  <= 1'b0;
      end else begin
        e_valid <= 1'b1; e_O <= xm_O; e_D <= '0; e_ir <= xm_ir;
      end
    end else if (dmem_ack) begin
      m_busy <= 1'b0; e_valid <= 1'b1; e_O <= m_O; e_ir <= m_ir;
      e_D <= m_we ? 32'h0 : dmem_rdata;
    end else if (m_waited + 1 == MW) begin
      m_busy <= 1'b0; e_err <= 1'b1; e_valid <= 1'b1; e_O <= m_O; e_ir <= m_ir; e_D <= '0;
    end else begin
      m_waited <= m_waited + 1;
      e_valid  <= 1'b0;
    end
  end

  always @(negedge clock) begin
    chk("cyc_stall", stall, m_busy);
    chk("cyc_req", dmem_req, m_busy);
    chk("cyc_we", dmem_we, m_busy & m_we);
    chk("cyc_addr", dmem_addr, m_addr);
    chk("cyc_wdata", dmem_wdata, m_wdata);
    chk("cyc_mw_valid", mw_valid, e_valid);
    chk("cyc_mw_O", mw_O, e_O);
    chk("cyc_mw_D", mw_D, e_D);
    chk("cyc_mw_ir", mw_ir, e_ir);
    chk("cyc_mem_err", mem_err, e_err);
  end

  task automatic xm(input logic v, input logic [31:0] o, input logic [31:0] b, input logic [31:0] ir);
    xm_valid = v; xm_O = o; xm_B = b; xm_ir = ir;
  endtask

  initial begin
    ctrl_reset = 1'b1;
    xm(1'b0, 32'h0, 32'h0, 32'h0);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #1 ctrl_reset = 1'b0;
    @(negedge clock); @(negedge clock);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mw_valid", mw_valid, 1'b0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_addr", dmem_addr, 12'h000);
    ctrl_reset = 1'b1;
    @(negedge clock);

    // ALU pass-through
    xm(1'b1, 32'h0000_1234, 32'h0, IR_ALU);
    @(negedge clock);
    chk("alu_valid", mw_valid, 1'b1);
    chk("alu_O", mw_O, 32'h0000_1234);
    chk("alu_D", mw_D, 32'h0);
    chk("alu_stall", stall, 1'b0);

    // SW, ack on third ACCESS cycle
    xm(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, IR_SW);
    @(negedge clock);
    xm(1'b0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("sw_stall", stall, 1'b1);
      chk("sw_we", dmem_we, 1'b1);
      chk("sw_addr", dmem_addr, 12'h040);
      chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
      if (i == 2) dmem_ack = 1'b1;
      @(negedge clock);
    end
    dmem_ack = 1'b0;
    chk("sw_stall_drop", stall, 1'b0);
    chk("sw_valid", mw_valid, 1'b1);
    chk("sw_D", mw_D, 32'h0);
    chk("sw_O", mw_O, 32'h0000_0040);

    // LW with immediate ack, next LW queued behind it
    xm(1'b1, 32'h0000_0010, 32'h0, IR_LW);
    @(negedge clock);
    chk("lw_stall", stall, 1'b1);
    chk("lw_we", dmem_we, 1'b0);
    chk("lw_addr", dmem_addr, 12'h010);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    xm(1'b1, 32'h0000_0020, 32'h0, IR_LW);
    @(negedge clock);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("lw_valid", mw_valid, 1'b1);
    chk("lw_D", mw_D, 32'hCAFE_F00D);
    chk("lw_stall_drop", stall, 1'b0);
    @(negedge clock);
    xm(1'b0, 32'h0, 32'h0, 32'h0);
    chk("lw2_stall", stall, 1'b1);
    chk("lw2_addr", dmem_addr, 12'h020);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clock);
    dmem_ack = 1'b0;
    chk("lw2_D", mw_D, 32'h1234_5678);
    chk("lw2_O", mw_O, 32'h0000_0020);

    // Timeout after MW ack-less cycles
    xm(1'b1, 32'h0000_0030, 32'h0, IR_LW);
    @(negedge clock);
    xm(1'b0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_req", dmem_req, 1'b1);
      @(negedge clock);
    end
    chk("to_err", mem_err, 1'b1);
    chk("to_valid", mw_valid, 1'b1);
    chk("to_D", mw_D, 32'h0);
    chk("to_req_drop", dmem_req, 1'b0);
    @(negedge clock);
    chk("to_err_sticky", mem_err, 1'b1);

    ctrl_reset = 1'b0;
    @(negedge clock);
    chk("err_cleared", mem_err, 1'b0);
    ctrl_reset = 1'b1;

    // Ack on the terminal wait cycle completes normally
    xm(1'b1, 32'h0000_0034, 32'h0, IR_LW);
    @(negedge clock);
    xm(1'b0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("a4_req", dmem_req, 1'b1);
      if (i == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_5A5A; end
      @(negedge clock);
    end
    dmem_ack = 1'b0;
    chk("a4_err", mem_err, 1'b0);
    chk("a4_valid", mw_valid, 1'b1);
    chk("a4_D", mw_D, 32'hA5A5_5A5A);

    // Reset in the second wait cycle, then a stray ack
    xm(1'b1, 32'h0000_0044, 32'h0, IR_LW);
    @(negedge clock);
    xm(1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    #1 ctrl_reset = 1'b0;
    #1;
    chk("rm_stall", stall, 1'b0);
    chk("rm_req", dmem_req, 1'b0);
    @(negedge clock);
    ctrl_reset = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_0000;
    @(negedge clock);
    dmem_ack = 1'b0;
    chk("late_valid", mw_valid, 1'b0);
    chk("late_stall", stall, 1'b0);

    // Bubble with garbage instruction
    xm(1'b1, 32'h0000_0055, 32'h0, IR_ALU);
    @(negedge clock);
    chk("bub_pre_ir", mw_ir, 32'h0000_00AB);
    xm(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clock);
    chk("bub_valid", mw_valid, 1'b0);
    chk("bub_ir", mw_ir, 32'h0);
    chk("bub_req", dmem_req, 1'b0);
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
